jk_seq_controller: RTL and testbench
====================================

Name: jk_seq_controller

Overview:
- Sequencer for a bank of JK flip-flops that makes it step through an arbitrary, programmable state sequence (arbitrary counter).
- Holds a writable sequence table and a step pointer.
- Generates the J/K excitation for each flip-flop so the bank moves to the next table entry on each active clock edge.
- Sits between the user/config interface and the JK flip-flop bank. Both live inside this block.

Parameters:
- WIDTH, 3, number of JK flip-flops (bits per counter state)
- DEPTH, 8, number of sequence-table entries
- AW, 3, pointer/address width, equal to clog2(DEPTH)

Ports:
- C  in  1  clock; all state updates on the falling edge
- nR  in  1  asynchronous active-low reset
- wr_en  in  1  table write strobe
- wr_addr  in  AW  table write address
- wr_data  in  WIDTH  table write data
- len  in  AW  index of the last valid entry (sequence length minus 1)
- start  in  1  begin sequence from entry 0
- stop  in  1  return to IDLE, holding Q
- step_en  in  1  advance one entry per edge while RUN
- busy  out  1  high in RUN
- idx  out  AW  current table pointer
- Q  out  WIDTH  flip-flop bank state
- J  out  WIDTH  excitation J (combinational)
- K  out  WIDTH  excitation K (combinational)
- wrap  out  1  one-cycle pulse when idx returns to 0 from len

Behaviour:
- Clock and reset: single clock C, falling-edge active. nR is asynchronous and active-low.
- Reset (nR=0) forces the following immediately:
  - FSM=IDLE, idx=0, Q=0, wrap=0, busy=0
  - all table entries=0
- FSM states:
  - IDLE to RUN on start=1 and stop=0.
  - RUN to IDLE on stop=1.
  - Otherwise the state holds.
- Target value, combinational:
  - IDLE with start: target = table[0].
  - RUN with step_en: target = table[nxt], where nxt = 0 if idx>=len, else idx+1.
  - All other cases: target = Q.
- Excitation: J = target & ~Q, K = ~target & Q. Toggle is never used. J=K=0 means hold.
- Edge updates:
  - The bank applies J/K at the falling edge, so Q equals target after that edge (zero-cycle latency from the sampled control).
  - idx loads 0 on start and nxt on a RUN step.
  - wrap=1 for exactly one cycle after a step where idx>=len.
- Table writes:
  - When wr_en=1, table[wr_addr] <= wr_data at the falling edge. Writes are legal in any state.
  - Write to the currently targeted entry in the same edge: the old contents are used. The new value applies from the next edge.
  - wr_addr >= DEPTH: the write is ignored.
- Boundary cases:
  - start and stop in the same edge: stop wins and the state stays or goes to IDLE.
  - start while in RUN: ignored.
  - len changed mid-run: compared live. If idx > new len, the next step goes to 0 and pulses wrap.
  - len=0: Q stays table[0], and wrap pulses on every step.
  - len >= DEPTH: treated as DEPTH-1.
  - step_en=0 in RUN: Q and idx hold, J=K=0.
  - nR asserted mid-run: immediate reset. Table contents are lost.
- busy equals (state==RUN).

Optional Feature:
- Macro: JK_SEQ_REVERSE_EN.
- When defined:
  - An extra input dir (1 bit) is present.
  - dir=1 steps backward: nxt = len if idx==0, else idx-1. wrap pulses when idx goes from 0 to len.
  - start still loads entry 0.
- When undefined: no dir port, forward stepping only.

Decomposition:
- Package jk_seq_pkg holds:
  - state enum {IDLE, RUN}
  - default WIDTH/DEPTH/AW constants
  - a function computing {J,K} from (target, Q)
- Sub-module jk_bank:
  - WIDTH falling-edge JK flip-flops with async active-low clear
  - ports C, nR, J, K, Q, nQ
  - standard JK table: 10 sets, 01 clears, 11 toggles, 00 holds

Test Plan:
- Reset/idle: nR pulse low → Q=0, idx=0, busy=0, J=K=0 in IDLE without start.
- Program and run:
  - Setup: write table 0..3 = 5,2,7,0; len=3; start then step_en=1.
  - Q sequence: 5,2,7,0,5.
  - wrap high only in the cycle after the 0→5 transition.
  - J/K check at Q=5 targeting 2: J=010, K=101.
- Hold and stop:
  - step_en=0 for 3 edges → Q and idx unchanged.
  - stop=1 → busy=0, Q held.
  - start and stop together → remains IDLE.
- Write during run: at idx=1, write table[2]=4 in the stepping edge → Q goes to the old 7 first; on the next lap, entry 2 yields 4.
- len edge cases:
  - len=0 → Q stays table[0], wrap every step.
  - At idx=3, set len=1 → next Q=table[0] with wrap.
- Async reset mid-run at Q=7 → Q=0 immediately without a clock edge, and all table entries read 0 afterwards.
- With JK_SEQ_REVERSE_EN defined: dir=1 from idx=0, len=3 → idx steps 3,2,1,0 with wrap on 0→3.

Source files
------------

// File: rtl/jk_seq_pkg.sv
// Shared types and helpers for the JK sequence controller.
// Holds the FSM state enum, default sizes and the JK excitation helper.
package jk_seq_pkg;

  localparam int DEF_WIDTH = 3;
  localparam int DEF_DEPTH = 8;
  localparam int DEF_AW    = 3;

  typedef enum logic {
    IDLE,
    RUN
  } state_t;

  // Excitation that moves one flip-flop from q to t.
  // Only set or clear is ever requested; toggle never is.
  function automatic logic [1:0] jk_excite(
    input logic t,
    input logic q
  );
    return {t & ~q, ~t & q};
  endfunction

endpackage

// File: rtl/jk_bank.sv
// Bank of falling-edge JK flip-flops with async active-low clear.
// 10 sets, 01 clears, 11 toggles, 00 holds.
import jk_seq_pkg::*;

module jk_bank #(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             C,
  input  logic             nR,
  input  logic [WIDTH-1:0] J,
  input  logic [WIDTH-1:0] K,
  output logic [WIDTH-1:0] Q,
  output logic [WIDTH-1:0] nQ
);

  // Per-bit JK characteristic on the falling edge.
  always_ff @(negedge C or negedge nR) begin
    if (!nR) begin
      Q <= '0;
    end else begin
      for (int i = 0; i < WIDTH; i++) begin
        unique case ({J[i], K[i]})
          2'b10:   Q[i] <= 1'b1;
          2'b01:   Q[i] <= 1'b0;
          2'b11:   Q[i] <= ~Q[i];
          default: Q[i] <= Q[i];
        endcase
      end
    end
  end

  assign nQ = ~Q;

endmodule

// File: rtl/jk_seq_controller.sv
// Programmable-sequence controller driving a JK flip-flop bank.
// Optional backward stepping via `define JK_SEQ_REVERSE_EN (adds dir).
import jk_seq_pkg::*;

module jk_seq_controller #(
  parameter int WIDTH = DEF_WIDTH,
  parameter int DEPTH = DEF_DEPTH,
  parameter int AW    = DEF_AW
) (
  input  logic             C,
  input  logic             nR,
  input  logic             wr_en,
  input  logic [AW-1:0]    wr_addr,
  input  logic [WIDTH-1:0] wr_data,
  input  logic [AW-1:0]    len,
  input  logic             start,
  input  logic             stop,
  input  logic             step_en,
`ifdef JK_SEQ_REVERSE_EN
  input  logic             dir,
`endif
  output logic             busy,
  output logic [AW-1:0]    idx,
  output logic [WIDTH-1:0] Q,
  output logic [WIDTH-1:0] J,
  output logic [WIDTH-1:0] K,
  output logic             wrap
);

  localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);

  state_t           state;
  logic [WIDTH-1:0] tbl [DEPTH];
  logic [AW-1:0]    len_eff;
  logic [AW-1:0]    nxt;
  logic [WIDTH-1:0] target;
  logic [WIDTH-1:0] unused_nq;
  logic             rev;
  logic             start_go;
  logic             step_go;
  logic             at_wrap;
  logic             wr_ok;

`ifdef JK_SEQ_REVERSE_EN
  assign rev = dir;
`else
  assign rev = 1'b0;
`endif

  // Out-of-range lengths saturate to the last entry.
  assign len_eff = (32'(len) >= DEPTH) ? LAST : len;
  assign wr_ok   = 32'(wr_addr) < DEPTH;

  // Stop outranks both start and stepping.
  assign start_go = (state == IDLE) & start & ~stop;
  assign step_go  = (state == RUN) & step_en & ~stop;

  // Next pointer and wrap condition, compared live against len.
  always_comb begin
    at_wrap = 1'b0;
    nxt     = '0;
    if (rev) begin
      at_wrap = (idx == '0);
      nxt     = at_wrap ? len_eff : idx - 1'b1;
    end else begin
      at_wrap = (idx >= len_eff);
      nxt     = at_wrap ? '0 : idx + 1'b1;
    end
  end

  // Target state: table reads see pre-edge contents.
  always_comb begin
    target = Q;
    if (start_go)
      target = tbl[0];
    else if (step_go)
      target = tbl[nxt];
  end

  // Per-bit excitation toward target.
  always_comb begin
    J = '0;
    K = '0;
    for (int i = 0; i < WIDTH; i++)
      {J[i], K[i]} = jk_excite(target[i], Q[i]);
  end

  jk_bank #(
    .WIDTH (WIDTH)
  ) u_bank (
    .C  (C),
    .nR (nR),
    .J  (J),
    .K  (K),
    .Q  (Q),
    .nQ (unused_nq)
  );

  // Control FSM with registered busy, idx and wrap.
  always_ff @(negedge C or negedge nR) begin
    if (!nR) begin
      state <= IDLE;
      busy  <= 1'b0;
      idx   <= '0;
      wrap  <= 1'b0;
    end else begin
      wrap <= step_go & at_wrap;
      unique case (state)
        IDLE: begin
          if (start_go) begin
            state <= RUN;
            busy  <= 1'b1;
            idx   <= '0;
          end
        end
        RUN: begin
          if (stop) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else if (step_en) begin
            idx <= nxt;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  // Sequence table; cleared by reset, writable any time.
  always_ff @(negedge C or negedge nR) begin
    if (!nR) begin
      for (int i = 0; i < DEPTH; i++)
        tbl[i] <= '0;
    end else if (wr_en && wr_ok) begin
      tbl[wr_addr] <= wr_data;
    end
  end

endmodule

// File: tb/tb_jk_seq_controller.sv
// Testbench for jk_seq_controller: directed steps then random traffic.
// Reverse stepping is exercised when JK_SEQ_REVERSE_EN is defined.
module tb_jk_seq_controller;

  logic       C;
  logic       nR;
  logic       wr_en;
  logic [2:0] wr_addr;
  logic [2:0] wr_data;
  logic [2:0] len;
  logic       start;
  logic       stop;
  logic       step_en;
  logic       dir;
  logic       busy;
  logic [2:0] idx;
  logic [2:0] Q;
  logic [2:0] J;
  logic [2:0] K;
  logic       wrap;

  int checks = 0;
  int errors = 0;

  int         m_tbl [8];
  int         m_q;
  int         m_idx;
  bit         m_run;
  bit         m_wrap;
  logic [2:0] prog [4];

  jk_seq_controller dut (
    .C       (C),
    .nR      (nR),
    .wr_en   (wr_en),
    .wr_addr (wr_addr),
    .wr_data (wr_data),
    .len     (len),
    .start   (start),
    .stop    (stop),
    .step_en (step_en),
`ifdef JK_SEQ_REVERSE_EN
    .dir     (dir),
`endif
    .busy    (busy),
    .idx     (idx),
    .Q       (Q),
    .J       (J),
    .K       (K),
    .wrap    (wrap)
  );

  initial C = 1'b0;
  always #5 C = ~C;

  task automatic chk3(input string tag,
                      input logic [2:0] obs,
                      input logic [2:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d",
             tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag,
                      input logic obs,
                      input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d",
             tag, obs, exp);
    end
  endtask

  task automatic m_reset();
    for (int i = 0; i < 8; i++) m_tbl[i] = 0;
    m_q    = 0;
    m_idx  = 0;
    m_run  = 0;
    m_wrap = 0;
  endtask

  // One falling edge: predict from the sequence rules, then compare.
  task automatic cyc(input string tag);
    int  l, nx, tgt;
    bit  go, stp, rv, wr;
    #1;
    l  = int'(len);
    rv = 0;
`ifdef JK_SEQ_REVERSE_EN
    rv = dir;
`endif
    go  = !m_run && start && !stop;
    stp = m_run && step_en && !stop;
    if (rv) nx = (m_idx == 0) ? l : m_idx - 1;
    else    nx = (m_idx >= l) ? 0 : m_idx + 1;
    if (go)       tgt = m_tbl[0];
    else if (stp) tgt = m_tbl[nx];
    else          tgt = m_q;
    chk3({tag, ".J"}, J, 3'(tgt & ~m_q));
    chk3({tag, ".K"}, K, 3'(~tgt & m_q));
    wr = stp && (rv ? (m_idx == 0) : (m_idx >= l));
    if (wr_en) m_tbl[wr_addr] = int'(wr_data);
    if (go) begin
      m_run = 1;
      m_idx = 0;
    end else if (m_run && stop) begin
      m_run = 0;
    end else if (stp) begin
      m_idx = nx;
    end
    m_q    = tgt;
    m_wrap = wr;
    @(negedge C);
    #1;
    chk3({tag, ".Q"}, Q, 3'(m_q));
    chk3({tag, ".idx"}, idx, 3'(m_idx));
    chk1({tag, ".busy"}, busy, m_run);
    chk1({tag, ".wrap"}, wrap, m_wrap);
  endtask

  initial begin
    nR = 0; wr_en = 0; wr_addr = 0; wr_data = 0;
    len = 0; start = 0; stop = 0; step_en = 0; dir = 0;
    m_reset();
    prog[0] = 3'd5; prog[1] = 3'd2;
    prog[2] = 3'd7; prog[3] = 3'd0;
    #3;
    chk3("rst.Q", Q, 3'd0);
    chk3("rst.idx", idx, 3'd0);
    chk1("rst.busy", busy, 1'b0);
    chk1("rst.wrap", wrap, 1'b0);
    @(negedge C); #1;
    nR = 1;
    #1;
    chk3("idle.J", J, 3'd0);
    chk3("idle.K", K, 3'd0);

    wr_en = 1;
    for (int i = 0; i < 4; i++) begin
      wr_addr = 3'(i);
      wr_data = prog[i];
      cyc("prog");
    end
    wr_en = 0;
    len = 3;
    start = 1;
    cyc("start");
    start = 0;
    chk3("start_q", Q, 3'd5);
    step_en = 1;
    #1;
    chk3("jk5to2.J", J, 3'b010);
    chk3("jk5to2.K", K, 3'b101);
    cyc("run1");
    cyc("run2");
    cyc("run3");
    chk1("nowrap", wrap, 1'b0);
    cyc("run4");
    chk3("lap.Q", Q, 3'd5);
    chk1("lap.wrap", wrap, 1'b1);

    step_en = 0;
    repeat (3) cyc("hold");
    chk3("hold.idx", idx, 3'd0);
    stop = 1;
    cyc("stop");
    stop = 0;
    chk1("stop.busy", busy, 1'b0);
    start = 1; stop = 1;
    cyc("startstop");
    start = 0; stop = 0;
    chk1("ss.busy", busy, 1'b0);

    start = 1;
    cyc("restart");
    start = 0;
    step_en = 1;
    cyc("to1");
    wr_en = 1; wr_addr = 2; wr_data = 4;
    cyc("wr_run");
    wr_en = 0;
    chk3("old7", Q, 3'd7);
    repeat (3) cyc("lap2");
    cyc("new");
    chk3("new4", Q, 3'd4);

    len = 0;
    for (int i = 0; i < 3; i++) begin
      cyc("len0");
      chk3("len0.Q", Q, 3'd5);
      chk1("len0.wrap", wrap, 1'b1);
    end
    len = 3;
    repeat (3) cyc("to3");
    len = 1;
    cyc("shrink");
    chk3("shrink.Q", Q, 3'd5);
    chk1("shrink.wrap", wrap, 1'b1);

    len = 3;
    step_en = 0;
    wr_en = 1; wr_addr = 2; wr_data = 7;
    cyc("rewr");
    wr_en = 0;
    step_en = 1;
    cyc("to1b");
    cyc("to2b");
    chk3("pre_rst", Q, 3'd7);
    step_en = 0;
    #3;
    nR = 0;
    #1;
    chk3("arst.Q", Q, 3'd0);
    chk3("arst.idx", idx, 3'd0);
    chk1("arst.busy", busy, 1'b0);
    m_reset();
    @(negedge C); #1;
    nR = 1;
    len = 7;
    start = 1;
    cyc("zstart");
    start = 0;
    step_en = 1;
    repeat (8) cyc("zero");
    chk3("zero.Q", Q, 3'd0);
    step_en = 0;
    stop = 1;
    cyc("zstop");
    stop = 0;

`ifdef JK_SEQ_REVERSE_EN
    wr_en = 1;
    for (int i = 0; i < 4; i++) begin
      wr_addr = 3'(i);
      wr_data = 3'(i + 1);
      cyc("rprog");
    end
    wr_en = 0;
    len = 3;
    start = 1;
    cyc("rstart");
    start = 0;
    dir = 1;
    step_en = 1;
    cyc("rev1");
    chk3("rev.idx", idx, 3'd3);
    chk1("rev.wrap", wrap, 1'b1);
    cyc("rev2");
    cyc("rev3");
    cyc("rev4");
    chk3("rev.end", idx, 3'd0);
    dir = 0;
    step_en = 0;
    stop = 1;
    cyc("rstop");
    stop = 0;
`endif

    for (int n = 0; n < 400; n++) begin
      wr_en   = ($urandom_range(0, 3) == 0);
      wr_addr = 3'($urandom);
      wr_data = 3'($urandom);
      if ($urandom_range(0, 9) == 0) len = 3'($urandom);
      start   = ($urandom_range(0, 3) == 0);
      stop    = ($urandom_range(0, 19) == 0);
      step_en = ($urandom_range(0, 3) != 0);
      dir     = 1'($urandom);
      cyc("rand");
    end

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
